// File: rtl/mcp3008_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcp3008_pkg
// Brief    : Shared types, frame constants and channel-picking helpers.
// Revision : 1.0
// ============================================================================
package mcp3008_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CS_SETUP = 3'd1,
        S_CLOCK    = 3'd2,
        S_CS_HOLD  = 3'd3,
        S_CS_GAP   = 3'd4
    } state_t;

    localparam int CMD_BITS   = 5;
    localparam int CONV_SCLKS = 17;
    localparam int DATA_FIRST = 7;
    localparam int DATA_BITS  = 10;
    localparam int NUM_CH     = 8;

    // Index of the lowest set bit; 0 for an empty mask.
    function automatic logic [2:0] lowest_set(input logic [NUM_CH-1:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] bits_above(input logic [2:0] ch);
        return 8'hFE << ch;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcp3008_sclk_div.sv
`default_nettype none
// ============================================================================
// Module   : mcp3008_sclk_div
// Brief    : SCLK half-period counter with registered sclk and edge ticks.
// Revision : 1.0
// ============================================================================
module mcp3008_sclk_div #(
    parameter int HALF_DIV = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_run,
    output logic o_half_end,
    output logic o_sclk,
    output logic o_rise_tick,
    output logic o_fall_tick
);
    localparam int              c_CNT_W = $clog2(HALF_DIV);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(HALF_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_sclk;
    logic               r_rise;
    logic               r_fall;
    logic               w_half_end;

    assign w_half_end = i_en && (r_cnt == c_LAST);

    // i_run gates toggling so the FSM can hold sclk low for whole half-periods.
    always_ff @(posedge clk) begin
        if (!rst_n || !i_en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_cnt  <= w_half_end ? '0 : r_cnt + 1'b1;
            r_rise <= w_half_end && i_run && !r_sclk;
            r_fall <= w_half_end && i_run && r_sclk;
            if (w_half_end && i_run) r_sclk <= ~r_sclk;
        end
    end

    assign o_half_end  = w_half_end;
    assign o_sclk      = r_sclk;
    assign o_rise_tick = r_rise;
    assign o_fall_tick = r_fall;

endmodule
`default_nettype wire

// File: rtl/mcp3008_scanner.sv
`default_nettype none
// ============================================================================
// Module   : mcp3008_scanner
// Brief    : Autonomous round-robin SPI master for the MCP3008 8-channel ADC.
// Revision : 1.0
// ============================================================================
module mcp3008_scanner
    import mcp3008_pkg::*;
#(
    parameter int HALF_DIV       = 20,
    parameter int CS_HIGH_HALVES = 2,
    parameter int SINGLE_ENDED   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [NUM_CH-1:0]    ch_mask,
    output logic                 adc_sclk,
    output logic                 adc_cs_n,
    output logic                 adc_din,
    input  logic                 adc_dout,
    output logic                 busy,
    output logic                 sample_valid,
    output logic [2:0]           sample_ch,
    output logic [DATA_BITS-1:0] sample_data,
    output logic                 scan_done,
    output logic [DATA_BITS-1:0] result [NUM_CH]
);
    localparam int                 c_GAP_CLKS   = CS_HIGH_HALVES * HALF_DIV;
    localparam int                 c_GAP_W      = $clog2(c_GAP_CLKS);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST   = c_GAP_W'(c_GAP_CLKS - 1);
    localparam logic [4:0]         c_RISES_END  = 5'(CONV_SCLKS);
    localparam logic [4:0]         c_DATA_FIRST = 5'(DATA_FIRST);
    localparam logic [4:0]         c_CMD_BITS   = 5'(CMD_BITS);
    localparam logic               c_SGL        = 1'(SINGLE_ENDED);

    state_t                r_state;
    state_t                w_next;
    logic [4:0]            r_rises;
    logic [c_GAP_W-1:0]    r_gap;
    logic [NUM_CH-1:0]     r_mask;
    logic [2:0]            r_ch;
    logic                  r_stop;
    logic                  r_dout_s1;
    logic                  r_dout_s2;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_din;
    logic                  r_sample_valid;
    logic [2:0]            r_sample_ch;
    logic [DATA_BITS-1:0]  r_sample_data;
    logic                  r_scan_done;
    logic [DATA_BITS-1:0]  r_result [NUM_CH];

    logic                  w_cs_n;
    logic                  w_busy;
    logic                  w_div_en;
    logic                  w_sclk_run;
    logic                  w_half_end;
    logic                  w_sclk;
    logic                  w_rise_tick;
    logic                  w_fall_tick;
    logic [NUM_CH-1:0]     w_above;
    logic                  w_has_next;
    logic                  w_stop;
    logic                  w_gap_end;
    logic                  w_start_scan;
    logic                  w_next_conv;
    logic                  w_clock_end;
    logic                  w_hold_end;
    logic [CMD_BITS-1:0]   w_cmd;
    logic                  w_cmd_bit;

    mcp3008_sclk_div #(
        .HALF_DIV (HALF_DIV)
    ) u_sclk_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (w_div_en),
        .i_run       (w_sclk_run),
        .o_half_end  (w_half_end),
        .o_sclk      (w_sclk),
        .o_rise_tick (w_rise_tick),
        .o_fall_tick (w_fall_tick)
    );

    assign w_above      = r_mask & bits_above(r_ch);
    assign w_has_next   = |w_above;
    assign w_stop       = r_stop | ~enable;
    assign w_gap_end    = (r_state == S_CS_GAP) && (r_gap == c_GAP_LAST);
    assign w_start_scan = ((r_state == S_IDLE) && enable && (|ch_mask)) ||
                          (w_gap_end && !w_stop && !w_has_next && (|ch_mask));
    assign w_next_conv  = w_gap_end && !w_stop && w_has_next;
    // CLOCK ends one low half-period after the 17th falling edge.
    assign w_clock_end  = (r_state == S_CLOCK) && w_half_end && !w_sclk &&
                          (r_rises == c_RISES_END);
    assign w_hold_end   = (r_state == S_CS_HOLD) && w_half_end;

    assign w_cmd     = {1'b1, c_SGL, r_ch};
    assign w_cmd_bit = (r_rises < c_CMD_BITS) ? w_cmd[3'(c_CMD_BITS - 5'd1 - r_rises)] : 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_start_scan) w_next = S_CS_SETUP;
            S_CS_SETUP: if (w_half_end)   w_next = S_CLOCK;
            S_CLOCK:    if (w_clock_end)  w_next = S_CS_HOLD;
            S_CS_HOLD:  if (w_half_end)   w_next = S_CS_GAP;
            S_CS_GAP:   if (w_gap_end)    w_next = (w_start_scan || w_next_conv) ? S_CS_SETUP : S_IDLE;
            default:                      w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_cs_n     = 1'b1;
        w_busy     = 1'b0;
        w_div_en   = 1'b0;
        w_sclk_run = 1'b0;
        case (r_state)
            S_CS_SETUP: begin
                w_cs_n = 1'b0; w_busy = 1'b1; w_div_en = 1'b1; w_sclk_run = 1'b1;
            end
            S_CLOCK: begin
                w_cs_n = 1'b0; w_busy = 1'b1; w_div_en = 1'b1;
                w_sclk_run = !((r_rises == c_RISES_END) && !w_sclk);
            end
            S_CS_HOLD: begin
                w_cs_n = 1'b0; w_busy = 1'b1; w_div_en = 1'b1;
            end
            S_CS_GAP:  w_busy = 1'b1;
            default:   w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rises        <= '0;
            r_gap          <= '0;
            r_mask         <= '0;
            r_ch           <= '0;
            r_stop         <= 1'b0;
            r_dout_s1      <= 1'b0;
            r_dout_s2      <= 1'b0;
            r_shift        <= '0;
            r_din          <= 1'b0;
            r_sample_valid <= 1'b0;
            r_sample_ch    <= '0;
            r_sample_data  <= '0;
            r_scan_done    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) r_result[i] <= '0;
        end else begin
            r_dout_s1 <= adc_dout;
            r_dout_s2 <= r_dout_s1;
            // A low enable anywhere in a scan ends it after the current conversion.
            r_stop    <= (r_state == S_IDLE) ? 1'b0 : (r_stop | ~enable);
            r_gap     <= (r_state == S_CS_GAP) ? r_gap + 1'b1 : '0;

            if (r_state != S_CLOCK) r_rises <= '0;
            else if (w_rise_tick)   r_rises <= r_rises + 5'd1;

            if (w_start_scan) begin
                r_mask <= ch_mask;
                r_ch   <= lowest_set(ch_mask);
            end else if (w_next_conv) begin
                r_ch   <= lowest_set(w_above);
            end

            if ((r_state == S_CLOCK) && w_rise_tick &&
                (r_rises >= c_DATA_FIRST) && (r_rises < c_RISES_END))
                r_shift <= {r_shift[DATA_BITS-2:0], r_dout_s2};

            // DIN only moves while sclk is low: set up front, then after each fall.
            case (r_state)
                S_CS_SETUP: r_din <= 1'b1;
                S_CLOCK:    if (w_fall_tick) r_din <= w_cmd_bit;
                default:    r_din <= 1'b0;
            endcase

            r_sample_valid <= w_hold_end;
            r_scan_done    <= w_hold_end && !w_has_next;
            if (w_hold_end) begin
                r_sample_ch      <= r_ch;
                r_sample_data    <= r_shift;
                r_result[r_ch]   <= r_shift;
            end
        end
    end

    assign adc_sclk     = w_sclk;
    assign adc_cs_n     = w_cs_n;
    assign adc_din      = r_din;
    assign busy         = w_busy;
    assign sample_valid = r_sample_valid;
    assign sample_ch    = r_sample_ch;
    assign sample_data  = r_sample_data;
    assign scan_done    = r_scan_done;
    assign result       = r_result;

endmodule
`default_nettype wire

// File: doc/mcp3008_scanner.md
# mcp3008_scanner

Autonomous SPI master for the MCP3008 8-channel 10-bit ADC. It replaces the hand-sequenced CS/DIN/DOUT logic in the motor-control top level. It round-robins over a masked set of channels and emits one tagged sample per conversion. Downstream consumers (accel mapping, current/battery scaling, CAN payload) take its `sample_*` stream or the per-channel result registers.

## Interface
Parameters:
- `HALF_DIV`, 20: clk cycles per SCLK half-period; legal range ≥4 (20 gives 1.25 MHz at 50 MHz clk).
- `CS_HIGH_HALVES`, 2: SCLK half-periods that cs_n stays high between conversions; legal range ≥1.
- `SINGLE_ENDED`, 1: value driven on the SGL/DIFF command bit.

Ports:
- `clk`, in, 1: system clock, 50 MHz.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `enable`, in, 1: scans run continuously while high.
- `ch_mask`, in, 8: bit i set selects channel i for scanning.
- `adc_sclk`, out, 1: SPI clock to the MCP3008.
- `adc_cs_n`, out, 1: chip select, active low.
- `adc_din`, out, 1: command bits to the ADC.
- `adc_dout`, in, 1: asynchronous data from the ADC.
- `busy`, out, 1: high from leaving IDLE until the return to IDLE.
- `sample_valid`, out, 1: one-clk pulse when a conversion result is available.
- `sample_ch`, out, 3: channel of the current result.
- `sample_data`, out, 10: conversion result, unsigned.
- `scan_done`, out, 1: one-clk pulse that coincides with the last channel's `sample_valid`.
- `result[8]`, out, 10 each: last result per channel; updated when that channel's `sample_valid` fires.

## Operation
- States:
  - IDLE
  - CS_SETUP: cs_n low, sclk low, lasts 1 half-period.
  - CLOCK: 17 SCLK periods.
  - CS_HOLD: sclk low, cs_n low, lasts 1 half-period.
  - CS_GAP: cs_n high, lasts `CS_HIGH_HALVES` half-periods.
- IDLE → CS_SETUP when `enable`=1 and `ch_mask`≠0.
  - `ch_mask` is latched at this point. The latch is used for the whole scan.
  - The first channel is the lowest set bit.
- CLOCK, SCLK period k=0..16:
  - adc_din = 1 (start), SINGLE_ENDED, D2, D1, D0 for k=0..4.
  - adc_din = 0 for k≥5.
  - adc_din changes only while sclk is low.
  - adc_dout is sampled at the rising edges of k=7..16, giving B9..B0 MSB first.
  - k=5 is the sample period. k=6 carries the null bit, which is ignored.
- CS_HOLD → CS_GAP. On entry to CS_GAP:
  - Pulse `sample_valid`, drive `sample_ch`/`sample_data`, and update `result[ch]`.
  - Pulse `scan_done` if this was the highest set bit of the latched mask.
- CS_GAP exit:
  - Next set channel exists → CS_SETUP.
  - Otherwise, if `enable`=1 and live `ch_mask`≠0 → CS_SETUP of a new scan (mask re-latched).
  - Otherwise → IDLE.
- `enable` dropping mid-conversion: the conversion completes and is reported. The block then goes to IDLE after CS_GAP, and the remaining scan channels are skipped.
- `ch_mask` changes mid-scan have no effect until the next scan.
- adc_dout passes through a 2-flop synchronizer. This is sufficient because the ADC updates DOUT on the falling edge, ≥`HALF_DIV` clk before the sampling edge.

## Timing
- Reset values:
  - adc_cs_n = 1; adc_sclk = 0; adc_din = 0.
  - busy = 0; sample_valid = 0; scan_done = 0.
  - sample_ch = 0; sample_data = 0; all `result` = 0.
  - State = IDLE; phase counter = 0.
- Reset asserted mid-operation: all of the above on the next clk edge. No partial result is emitted.
- The phase counter counts 0..HALF_DIV-1. adc_sclk toggles on the clk after count HALF_DIV-1.
- Conversion period = (36 + CS_HIGH_HALVES) × HALF_DIV clk. Defaults: 760 clk (15.2 µs).
- The first sclk rise comes HALF_DIV clk after adc_cs_n falls.
- adc_cs_n falls on the clk after `enable` is seen high in IDLE.
- `sample_valid` is registered and coincides with adc_cs_n rising.
- `busy` rises with adc_cs_n falling and falls on the clk the state returns to IDLE.

## Structure
- Package `mcp3008_pkg` holds:
  - `state_t` enum.
  - `CMD_BITS`=5, `CONV_SCLKS`=17, `DATA_FIRST`=7, `DATA_BITS`=10.
  - `NUM_CH`=8.
- Sub-module `mcp3008_sclk_div` holds the phase counter. It generates one-clk `rise_tick`/`fall_tick` and the registered sclk, and is enabled only in CS_SETUP/CLOCK/CS_HOLD.
- The FSM, shifter, channel picker (next set bit above current) and result registers live in the top module.

## Test plan
- ch_mask=0x20, enable=1, ADC model returns 0x2A5: every 760 clk, sample_valid with ch=5, data=0x2A5, and scan_done on the same clk. DIN bits on rises 0..4 are 1,1,1,0,1.
- ch_mask=0xA1, distinct model values per channel: ch order 0,5,7,0,…. scan_done only with ch=7. result[0]/[5]/[7] match the model; all other result entries stay 0.
- enable low for 1 clk in the middle of CLOCK: that conversion is still reported. The block then goes to IDLE with busy=0 and adc_cs_n=1.
- ch_mask 0x03→0x80 during a scan: channel 1 is still converted. The next scan converts channel 7 only.
- rst_n low for 1 clk at k=9: next clk all outputs are at reset values, with no sample_valid.
- ch_mask=0, enable=1: the block stays in IDLE. adc_cs_n stays 1 and adc_sclk never toggles.
